// File: rtl/half_adder_unit.sv
// rtl/half_adder_unit.sv - registered multi-lane half adder with valid/ready stream and two-entry output skid buffer
module half_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] skid_carry;
  logic [WIDTH-1:0] skid_sum;
  logic             accept;
  logic             drain;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  // in_ready depends only on registered state, so out_ready never reaches it combinationally
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nxt     = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_out_new = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out_new = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          load_out_skid = 1'b1;
          state_nxt     = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands are only sampled on an accepted transfer, so idle X on a/b never lands in storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry      <= '0;
      sum        <= '0;
      skid_carry <= '0;
      skid_sum   <= '0;
    end else begin
      if (load_out_new) begin
        carry <= a & b;
        sum   <= a ^ b;
      end else if (load_out_skid) begin
        carry <= skid_carry;
        sum   <= skid_sum;
      end
      if (load_skid) begin
        skid_carry <= a & b;
        skid_sum   <= a ^ b;
      end
    end
  end

endmodule

// File: tb/tb_half_adder_unit.sv
// tb/tb_half_adder_unit.sv - directed and random self-checking bench for half_adder_unit
module tb_half_adder_unit;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             out_valid;
  logic             out_ready;

  int checks;
  int failures;

  half_adder_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry     (carry),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || carry !== 4'h0 || sum !== 4'h0) begin
      failures++;
      $display("FAIL reset: out_valid=%b in_ready=%b carry=%h sum=%h, required 0 1 0 0",
               out_valid, in_ready, carry, sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_truth_table();
    logic [3:0] av;
    logic [3:0] bv;
    logic [3:0] exp_c;
    logic [3:0] exp_s;
    av = 4'b0011; bv = 4'b0101; exp_c = 4'b0001; exp_s = 4'b0110;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = {WIDTH{av[i]}};
      b = {WIDTH{bv[i]}};
      tick();
      checks++;
      if (out_valid !== 1'b1 || carry !== {WIDTH{exp_c[i]}} || sum !== {WIDTH{exp_s[i]}}) begin
        failures++;
        $display("FAIL truth_table[%0d]: out_valid=%b carry=%h sum=%h, required 1 %h %h",
                 i, out_valid, carry, sum, {WIDTH{exp_c[i]}}, {WIDTH{exp_s[i]}});
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL truth_table_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 4'hF; b = 4'hF;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || carry !== 4'hF || sum !== 4'h0) begin
      failures++;
      $display("FAIL bp_first: in_ready=%b out_valid=%b carry=%h sum=%h, required 1 1 f 0",
               in_ready, out_valid, carry, sum);
    end
    a = 4'h0; b = 4'hF;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || carry !== 4'hF || sum !== 4'h0) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b carry=%h sum=%h, required 0 1 f 0",
               in_ready, out_valid, carry, sum);
    end
    a = 4'h5; b = 4'h3;
    tick();
    checks++;
    if (in_ready !== 1'b0 || carry !== 4'hF || sum !== 4'h0) begin
      failures++;
      $display("FAIL bp_hold: in_ready=%b carry=%h sum=%h, required 0 f 0", in_ready, carry, sum);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || carry !== 4'h0 || sum !== 4'hF) begin
      failures++;
      $display("FAIL bp_second: in_ready=%b out_valid=%b carry=%h sum=%h, required 1 1 0 f",
               in_ready, out_valid, carry, sum);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_multilane();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 4'b1100; b = 4'b1010;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sum !== 4'b0110 || carry !== 4'b1000) begin
      failures++;
      $display("FAIL multilane: out_valid=%b carry=%b sum=%b, required 1 1000 0110",
               out_valid, carry, sum);
    end
    tick();
  endtask

  task automatic test_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 4'hF : 4'bx;
      b = (i % 2 == 0) ? 4'h5 : 4'bx;
      tick();
      checks++;
      if (out_valid !== 1'b0 || carry !== 4'b1000 || sum !== 4'b0110) begin
        failures++;
        $display("FAIL idle[%0d]: out_valid=%b carry=%b sum=%b, required 0 1000 0110",
                 i, out_valid, carry, sum);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 4'h3; b = 4'h1;
    tick();
    a = 4'h6; b = 4'h2;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_full: in_ready=%b, required 0", in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || carry !== 4'h0 || sum !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid_async: out_valid=%b in_ready=%b carry=%h sum=%h, required 0 1 0 0",
               out_valid, in_ready, carry, sum);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = 4'h9; b = 4'hC;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || carry !== 4'h8 || sum !== 4'h5) begin
      failures++;
      $display("FAIL reset_mid_first: out_valid=%b carry=%h sum=%h, required 1 8 5",
               out_valid, carry, sum);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_leftover: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random_stress();
    logic [2*WIDTH-1:0] sb[$];
    logic [2*WIDTH-1:0] exp;
    int budget;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL random_extra: carry=%h sum=%h emitted with nothing expected", carry, sum);
        end else begin
          exp = sb.pop_front();
          if ({carry, sum} !== exp) begin
            failures++;
            $display("FAIL random_data: carry=%h sum=%h, required %h %h",
                     carry, sum, exp[2*WIDTH-1:WIDTH], exp[WIDTH-1:0]);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back({a & b, a ^ b});
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 10;
    while (sb.size() != 0 && budget > 0) begin
      #1;
      if (out_valid) begin
        checks++;
        exp = sb.pop_front();
        if ({carry, sum} !== exp) begin
          failures++;
          $display("FAIL random_drain: carry=%h sum=%h, required %h %h",
                   carry, sum, exp[2*WIDTH-1:WIDTH], exp[WIDTH-1:0]);
        end
      end
      tick();
      budget--;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_loss: pending=%0d out_valid=%b, required 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_truth_table();
    test_backpressure();
    test_multilane();
    test_idle();
    test_reset_mid();
    test_random_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder_unit.md
# half_adder_unit

Registered, multi-lane half adder with a valid/ready stream interface. Each lane computes the 1-bit sum (XOR) and carry (AND) of its two operand bits. Results appear one cycle after acceptance. A two-entry output skid buffer sustains one transfer per clock under backpressure. The block is a leaf arithmetic primitive used by adder trees and test datapaths, and sits between two valid/ready pipeline stages.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, default 1: number of independent half-adder lanes (WIDTH ≥ 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- carry  output  WIDTH  per-lane carry = a[i] & b[i].
- sum  output  WIDTH  per-lane sum = a[i] ^ b[i].
- out_valid  output  1  carry/sum hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.

## Operation
- Per lane i: sum[i] = a[i] XOR b[i]; carry[i] = a[i] AND b[i]. {carry[i], sum[i]} equals the 2-bit value a[i] + b[i].
- Lanes are fully independent. There is no carry propagation between lanes.
- Input transfer occurs when in_valid && in_ready at a rising edge. Output transfer occurs when out_valid && out_ready.
- Storage consists of an output register (OUT) and one skid register (SKID). States:
  - EMPTY: out_valid=0.
  - ONE: OUT full, SKID empty.
  - TWO: both full.
- in_ready = 1 in EMPTY and ONE, and 0 in TWO. in_ready is a function of registered state only, with no combinational path from out_ready.
- Transitions:
  - EMPTY + accept → ONE. The result is loaded into OUT.
  - ONE + accept + out transfer → ONE. OUT is replaced by the new result.
  - ONE + accept, no out transfer → TWO. The new result goes to SKID.
  - ONE + out transfer, no accept → EMPTY.
  - TWO + out transfer → ONE. SKID moves to OUT.
  - TWO, no out transfer → TWO. Data is held.
- Results leave in acceptance order. None are dropped or duplicated.
- While out_valid=1 and out_ready=0, carry/sum and out_valid hold stable.
- Input values when in_valid=0 or in_ready=0 are ignored. X on a/b without a transfer must not reach the outputs.

## Timing
- Latency: a result accepted at edge N is on carry/sum with out_valid=1 after edge N, provided OUT was empty or being drained.
- Throughput: 1 result/cycle when out_ready is held high.
- Reset (rst_n=0, asynchronous, immediate):
  - out_valid=0, carry=0, sum=0, in_ready=1.
  - SKID is cleared and the state is EMPTY.
- Reset mid-operation discards both stored results. The first accept after rst_n rises behaves as from EMPTY.
- Deassertion of rst_n is synchronised externally; the block assumes it is clean relative to clk.
- Simultaneous accept and out transfer in ONE is legal and loses nothing.

## Test plan
- Truth table (WIDTH=1, out_ready=1), a/b = 0/0, 0/1, 1/0, 1/1 on consecutive cycles → carry/sum = 0/0, 0/1, 0/1, 1/0, each one cycle later, with out_valid=1 on four consecutive cycles.
- Reset: assert rst_n=0 mid-stream with both registers full → out_valid=0, carry=sum=0, and in_ready=1 immediately, without waiting for a clock edge.
- Backpressure: out_ready=0, accept a=1,b=1 then a=0,b=1 → in_ready drops to 0. Outputs hold carry=1, sum=0. After out_ready=1, the bench sees 1/0 then 0/1 in order.
- Multi-lane (WIDTH=4): a=4'b1100, b=4'b1010 → sum=4'b0110, carry=4'b1000.
- Idle: in_valid=0 with toggling a/b → out_valid stays 0 and carry/sum do not change.
- Random stress: random in_valid/out_ready with random operands → the scoreboard matches a+b per lane, in order, with no loss.
